ahb_slave_resp_mux: RTL and testbench
=====================================

# ahb_slave_resp_mux

Registered-select AHB-Lite slave-response multiplexer, successor to the per-slave combinational one-hot response mux. It latches the decoder's address-phase one-hot select into a data-phase select on every accepted transfer. It forwards the selected slave's {HREADYOUT, HRESP, HRDATA} payload to the master side. It contains a built-in default slave that answers unmapped or illegal selects. It sits between the slave ports of one interconnect layer and the master-side read/response path, one instance per master.

## Interface
- CHANNEL_NUM, 2, number of slave channels (1..32)
- DATA_WIDTH, 32, HRDATA width (32 or 64)
- PAY_LOAD, DATA_WIDTH+2, payload width; bit [PAY_LOAD-1]=hreadyout, [PAY_LOAD-2]=hresp, [DATA_WIDTH-1:0]=hrdata
- One clock; reset is asynchronous and active-low.
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- hsel  in  CHANNEL_NUM  address-phase select from decoder, expected one-hot or zero
- htrans  in  2  address-phase HTRANS of the owning master
- payload_in  in  CHANNEL_NUM x PAY_LOAD  per-slave response payloads
- payload_out  out  PAY_LOAD  muxed response; hreadyout bit is the layer HREADY
- sel_err  out  1  one-cycle pulse when an accepted address phase carries a non-one-hot, non-zero hsel

## Operation
- Internal hready = payload_out[PAY_LOAD-1]; it gates every register update.
- On a rising HCLK with hready=1: dp_sel <= hsel; dp_act <= htrans[1] (NONSEQ/SEQ); dp_bad <= (hsel != 0) && !onehot(hsel).
- With hready=0, dp_sel, dp_act, and dp_bad hold.
- With dp_sel one-hot and dp_bad=0, payload_out = payload_in[index(dp_sel)] with zero-cycle combinational path.
- Otherwise the default slave drives the output (see Configuration).
- Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE -> DS_ERR1 on the clock edge that accepts an address phase with htrans[1]=1 and (hsel==0 or non-one-hot), macro enabled.
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if that edge accepts another erroring address phase, else DS_IDLE.
- Default-slave outputs:
  - DS_ERR1: hreadyout=0, hresp=1, hrdata=0.
  - DS_ERR2: hreadyout=1, hresp=1, hrdata=0.
  - DS_IDLE with no valid selection: hreadyout=1, hresp=0, hrdata=0.
- IDLE/BUSY transfers (htrans[1]=0) never cause ERROR:
  - If hsel is one-hot, the selected slave still answers (OKAY per protocol).
  - If hsel is zero, the default slave gives zero-wait OKAY.
- sel_err asserts for exactly the cycle following the accepting edge whenever dp_bad is set, regardless of htrans.

## Timing
- Reset (HRESETn low, asynchronous): dp_sel=0, dp_act=0, dp_bad=0, FSM=DS_IDLE, sel_err=0.
  - Resulting payload_out = {1'b1, 1'b0, 0}: ready, OKAY, zero data.
- Select latency: one cycle. The address phase in cycle N selects the data-phase payload in cycle N+1 onward, until the next hready=1 edge.
- Slave wait states: the selected slave's hreadyout=0 holds dp_sel, so the mux stays locked on that slave.
- The ERROR response is exactly two cycles (ERR1 then ERR2), per AHB two-cycle error rule.
- Back-to-back erroring transfers give ERR1, ERR2, ERR1, ERR2 with no idle between.
- A next valid one-hot address phase accepted in ERR2 switches to normal mux in the following cycle.
- Reset asserted mid-ERR1 or mid-slave-wait returns to the reset state immediately; no partial response is retained.
- No combinational path from hsel or htrans to payload_out.

## Configuration
- AHB_RESP_MUX_DEFAULT_SLAVE_EN defined:
  - Default-slave FSM is present.
  - An active transfer to an unmapped (hsel==0) or non-one-hot select returns a two-cycle ERROR.
- Not defined:
  - FSM is removed.
  - Any data phase without a valid one-hot dp_sel returns zero-wait OKAY, hrdata=0.
  - sel_err is still generated.

## Test plan
- Reset: hold HRESETn=0 mid-simulation -> payload_out = {1,0,0}, sel_err=0, asynchronously, before the next HCLK.
- Normal read, CHANNEL_NUM=4: hsel=4'b0100, htrans=NONSEQ at cycle N; payload_in[2] = {1,0,32'hDEADBEEF} -> payload_out = {1,0,32'hDEADBEEF} at N+1, with payload_in[2] changes ignored at N.
- Wait states: selected slave 1 drives hreadyout=0 for 3 cycles while hsel changes to 4'b0001 -> payload_out tracks slave 1 all 3 cycles; slave 0 is selected only after hreadyout=1.
- Unmapped access, macro on: hsel=0, htrans=NONSEQ -> ERR1 {0,1,0}, then ERR2 {1,1,0}, then OKAY; with the macro off, a single {1,0,0} cycle.
- Illegal select: hsel=4'b0110, htrans=SEQ -> sel_err high exactly 1 cycle plus two-cycle ERROR (macro on). The same with htrans=IDLE gives sel_err pulse and zero-wait OKAY.
- Reset mid-error: assert HRESETn low during ERR1, release -> FSM DS_IDLE, payload_out {1,0,0}, and the next valid transfer behaves normally.

Source files
------------

// File: rtl/ahb_slave_resp_mux_if.sv
// Bundle of decoder select, owning-master HTRANS, per-slave response payloads
// and the muxed layer response, plus FSM debug taps for checkers.
interface ahb_slave_resp_mux_if #(
   parameter int CHANNEL_NUM = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int PAY_LOAD    = DATA_WIDTH + 2
);
   logic [CHANNEL_NUM-1:0]               hsel;
   logic [1:0]                           htrans;
   logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_in;
   logic [PAY_LOAD-1:0]                  payload_out;
   logic                                 sel_err;
   logic [1:0]                           dbg_state;
   logic                                 dbg_dp_act;

   modport slave (
      input  hsel, htrans, payload_in,
      output payload_out, sel_err, dbg_state, dbg_dp_act
   );

   modport master (
      output hsel, htrans, payload_in,
      input  payload_out, sel_err, dbg_state, dbg_dp_act
   );
endinterface

// File: rtl/ahb_slave_resp_mux.sv
// Registered-select AHB-Lite response mux with built-in default slave.
// Define AHB_RESP_MUX_DEFAULT_SLAVE_EN to get two-cycle ERROR on bad selects.
module ahb_slave_resp_mux #(
   parameter int CHANNEL_NUM = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int PAY_LOAD    = DATA_WIDTH + 2
) (
   input logic                  HCLK,
   input logic                  HRESETn,
   ahb_slave_resp_mux_if.slave  bus
);

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [PAY_LOAD-1:0] PL_OKAY = {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};

   // Handshake: the layer HREADY is payload_out's top bit. An address phase is
   // accepted on a rising edge only when it is 1; while 0 every register holds.
   logic [CHANNEL_NUM-1:0] dp_sel_q, dp_sel_d;
   logic                   dp_act_q, dp_act_d;
   logic                   dp_bad_q, dp_bad_d;
   logic                   sel_err_q, sel_err_d;
   logic                   hready;
   logic                   act_in;
   logic                   bad_in;
   logic                   sel_valid;
   logic [PAY_LOAD-1:0]    slave_pl;
   logic [PAY_LOAD-1:0]    pl_out;
   ds_state_e              ds_q;

   always_comb begin
      hready    = pl_out[PAY_LOAD-1];
      act_in    = (bus.htrans == HT_NONSEQ) || (bus.htrans == HT_SEQ);
      bad_in    = (bus.hsel != '0) && ($countones(bus.hsel) != 1);
      dp_sel_d  = dp_sel_q;
      dp_act_d  = dp_act_q;
      dp_bad_d  = dp_bad_q;
      sel_err_d = 1'b0;
      if (hready) begin
         dp_sel_d  = bus.hsel;
         dp_act_d  = act_in;
         dp_bad_d  = bad_in;
         sel_err_d = bad_in;
      end
   end

   // dp_sel is one-hot whenever sel_valid is set, so an AND-OR mux suffices.
   always_comb begin
      sel_valid = ($countones(dp_sel_q) == 1) && !dp_bad_q;
      slave_pl  = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         slave_pl = slave_pl | (bus.payload_in[i] & {PAY_LOAD{dp_sel_q[i]}});
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_sel_q  <= '0;
         dp_act_q  <= 1'b0;
         dp_bad_q  <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         dp_sel_q  <= dp_sel_d;
         dp_act_q  <= dp_act_d;
         dp_bad_q  <= dp_bad_d;
         sel_err_q <= sel_err_d;
      end
   end

`ifdef AHB_RESP_MUX_DEFAULT_SLAVE_EN
   localparam logic [PAY_LOAD-1:0] PL_ERR1 = {1'b0, 1'b1, {DATA_WIDTH{1'b0}}};
   localparam logic [PAY_LOAD-1:0] PL_ERR2 = {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};

   ds_state_e ds_d;
   logic      err_in;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) ds_q <= DS_IDLE;
      else          ds_q <= ds_d;
   end

   // ERR1 drives hready low, so nothing is accepted until ERR2.
   always_comb begin
      err_in = act_in && ((bus.hsel == '0) || bad_in);
      ds_d   = ds_q;
      unique case (ds_q)
         DS_IDLE: if (hready && err_in) ds_d = DS_ERR1;
         DS_ERR1: ds_d = DS_ERR2;
         DS_ERR2: ds_d = (hready && err_in) ? DS_ERR1 : DS_IDLE;
         default: ds_d = DS_IDLE;
      endcase
   end

   always_comb begin
      pl_out = sel_valid ? slave_pl : PL_OKAY;
      if (ds_q == DS_ERR1) pl_out = PL_ERR1;
      if (ds_q == DS_ERR2) pl_out = PL_ERR2;
   end
`else
   assign ds_q = DS_IDLE;

   always_comb begin
      pl_out = sel_valid ? slave_pl : PL_OKAY;
   end
`endif

   assign bus.payload_out = pl_out;
   assign bus.sel_err     = sel_err_q;
   assign bus.dbg_state   = ds_q;
   assign bus.dbg_dp_act  = dp_act_q;

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Directed-vector bench for ahb_slave_resp_mux (4 slaves, 32-bit data);
// expectations follow AHB_RESP_MUX_DEFAULT_SLAVE_EN when it is defined.
module tb_ahb_slave_resp_mux;

   localparam int PL = 34;
   localparam int W  = PL + 1;

`ifdef AHB_RESP_MUX_DEFAULT_SLAVE_EN
   localparam bit DS_EN = 1'b1;
`else
   localparam bit DS_EN = 1'b0;
`endif

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   localparam logic [PL-1:0] OK0  = {1'b1, 1'b0, 32'h0};
   localparam logic [PL-1:0] ERR1 = {1'b0, 1'b1, 32'h0};
   localparam logic [PL-1:0] ERR2 = {1'b1, 1'b1, 32'h0};

   logic HCLK;
   logic HRESETn;

   ahb_slave_resp_mux_if #(.CHANNEL_NUM(4), .DATA_WIDTH(32)) bus_if ();

   ahb_slave_resp_mux #(.CHANNEL_NUM(4), .DATA_WIDTH(32)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if)
   );

   // clock / reset
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // scoreboard state
   logic [W-1:0]  exp_q[$];
   int            id_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            vec_id   = 0;
   logic [PL-1:0] pl_next [4];

   function automatic logic [PL-1:0] mk(input logic rdy, input logic rsp, input logic [31:0] d);
      return {rdy, rsp, d};
   endfunction

   function automatic logic [PL-1:0] dflt(input int i);
      logic [31:0] d;
      d = 32'hA000_0000 + 32'(i);
      return {1'b1, 1'b0, d};
   endfunction

   // driver: apply one cycle of inputs just after the rising edge and queue
   // the response expected during that cycle
   task automatic step(input logic rst_v, input logic [3:0] s, input logic [1:0] t,
                       input logic [PL-1:0] exp_pl, input logic exp_err);
      @(posedge HCLK);
      #1;
      HRESETn        = rst_v;
      bus_if.hsel    = s;
      bus_if.htrans  = t;
      for (int i = 0; i < 4; i++) bus_if.payload_in[i] = pl_next[i];
      exp_q.push_back({exp_err, exp_pl});
      id_q.push_back(vec_id);
      vec_id++;
   endtask

   // monitor: compare on the falling edge, away from the active edge
   logic [W-1:0] mon_got, mon_exp;
   int           mon_id;
   always @(negedge HCLK) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_id  = id_q.pop_front();
         mon_got = {bus_if.sel_err, bus_if.payload_out};
         checks++;
         if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL vec%0d {sel_err,payload_out} got=%h exp=%h", mon_id, mon_got, mon_exp);
         end
      end
   end

   initial begin
      HRESETn       = 1'b0;
      bus_if.hsel   = '0;
      bus_if.htrans = T_IDLE;
      for (int i = 0; i < 4; i++) begin
         pl_next[i]           = dflt(i);
         bus_if.payload_in[i] = dflt(i);
      end

      // reset and normal read through slave 2
      step(1'b0, 4'b0000, T_IDLE, OK0, 1'b0);
      pl_next[2] = mk(1'b1, 1'b0, 32'h1234_5678);
      step(1'b1, 4'b0100, T_NONSEQ, OK0, 1'b0);
      pl_next[2] = mk(1'b1, 1'b0, 32'hDEAD_BEEF);
      step(1'b1, 4'b0000, T_IDLE, mk(1'b1, 1'b0, 32'hDEAD_BEEF), 1'b0);
      pl_next[2] = dflt(2);

      // slave 1 inserts three wait states while the decoder moves to slave 0
      step(1'b1, 4'b0010, T_NONSEQ, OK0, 1'b0);
      pl_next[1] = mk(1'b0, 1'b0, 32'h1111_0001);
      step(1'b1, 4'b0001, T_NONSEQ, mk(1'b0, 1'b0, 32'h1111_0001), 1'b0);
      pl_next[1] = mk(1'b0, 1'b0, 32'h1111_0002);
      step(1'b1, 4'b0001, T_NONSEQ, mk(1'b0, 1'b0, 32'h1111_0002), 1'b0);
      pl_next[1] = mk(1'b0, 1'b0, 32'h1111_0003);
      step(1'b1, 4'b0001, T_NONSEQ, mk(1'b0, 1'b0, 32'h1111_0003), 1'b0);
      pl_next[1] = mk(1'b1, 1'b0, 32'h1111_0004);
      step(1'b1, 4'b0001, T_NONSEQ, mk(1'b1, 1'b0, 32'h1111_0004), 1'b0);
      pl_next[1] = dflt(1);
      step(1'b1, 4'b0000, T_IDLE, dflt(0), 1'b0);

      // unmapped active access
      step(1'b1, 4'b0000, T_NONSEQ, OK0, 1'b0);
      step(1'b1, 4'b0000, T_IDLE, DS_EN ? ERR1 : OK0, 1'b0);
      step(1'b1, 4'b0000, T_IDLE, DS_EN ? ERR2 : OK0, 1'b0);

      // illegal select: SEQ then IDLE
      step(1'b1, 4'b0110, T_SEQ, OK0, 1'b0);
      step(1'b1, 4'b0000, T_IDLE, DS_EN ? ERR1 : OK0, 1'b1);
      step(1'b1, 4'b0110, T_IDLE, DS_EN ? ERR2 : OK0, 1'b0);
      step(1'b1, 4'b0000, T_NONSEQ, OK0, 1'b1);

      // back-to-back errors, then a valid select accepted in ERR2
      step(1'b1, 4'b0000, T_NONSEQ, DS_EN ? ERR1 : OK0, 1'b0);
      step(1'b1, 4'b0000, T_NONSEQ, DS_EN ? ERR2 : OK0, 1'b0);
      step(1'b1, 4'b1000, T_NONSEQ, DS_EN ? ERR1 : OK0, 1'b0);
      step(1'b1, 4'b1000, T_NONSEQ, DS_EN ? ERR2 : dflt(3), 1'b0);
      step(1'b1, 4'b0000, T_IDLE, dflt(3), 1'b0);

      // reset asserted one time unit into ERR1
      step(1'b1, 4'b0000, T_NONSEQ, OK0, 1'b0);
      step(1'b0, 4'b0000, T_IDLE, OK0, 1'b0);
      #2;
      checks++;
      if (bus_if.dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_mid_err1 dbg_state got=%0d exp=0", bus_if.dbg_state);
      end
      step(1'b1, 4'b0010, T_NONSEQ, OK0, 1'b0);
      step(1'b1, 4'b0000, T_IDLE, dflt(1), 1'b0);
      step(1'b1, 4'b0000, T_IDLE, OK0, 1'b0);

      @(posedge HCLK);
      @(posedge HCLK);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
